// File: rtl/ram_dp_arbiter_if.sv
// Client-side bundle for ram_dp_arbiter: two write and two read requesters
// sharing one req/gnt handshake per channel, plus the shared read-return bus.
interface ram_dp_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic [1:0]        wr_req;
  logic [1:0]        wr_gnt;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        rd_req;
  logic [1:0]        rd_gnt;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [1:0]        rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req, rd_addr0, rd_addr1,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req, rd_addr0, rd_addr1,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_dp_arbiter.sv
// Two-client round-robin arbiter in front of a dual-port RAM: independent write
// and read channels, same-cycle address hazard stall, tagged fixed-latency return.
module ram_dp_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  ram_dp_arbiter_if.slave   bus,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_wr_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_rd_address,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic              wr_ptr;
  logic              rd_ptr;
  logic              wr_any;
  logic              rd_any;
  logic              wr_sel;
  logic              rd_sel;
  logic              hazard;
  logic              rd_fire;
  logic [ADDR_W-1:0] wr_addr_win;
  logic [ADDR_W-1:0] rd_addr_win;
  logic [DATA_W-1:0] wr_data_win;
  logic [RD_LAT:0][1:0] tag_pipe;

  // Winner index; a lone requester wins, a tie goes to the pointer holder.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    return (req == 2'b11) ? ptr : req[1];
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    bus.wr_gnt  = 2'b00;
    bus.rd_gnt  = 2'b00;
    wr_any      = resetn && (bus.wr_req != 2'b00);
    rd_any      = resetn && (bus.rd_req != 2'b00);
    wr_sel      = rr_pick(bus.wr_req, wr_ptr);
    rd_sel      = rr_pick(bus.rd_req, rd_ptr);
    wr_addr_win = wr_sel ? bus.wr_addr1 : bus.wr_addr0;
    wr_data_win = wr_sel ? bus.wr_data1 : bus.wr_data0;
    rd_addr_win = rd_sel ? bus.rd_addr1 : bus.rd_addr0;
    // A read racing a write to the same word waits one cycle so it sees the new data.
    hazard      = wr_any && rd_any && (wr_addr_win == rd_addr_win);
    rd_fire     = rd_any && !hazard;
    if (wr_any)  bus.wr_gnt[wr_sel] = 1'b1;
    if (rd_fire) bus.rd_gnt[rd_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (!resetn) begin
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      ram_write      <= 1'b0;
      ram_wr_address <= '0;
      ram_data_in    <= '0;
      ram_read       <= 1'b0;
      ram_rd_address <= '0;
      // NOTE: the tag pipeline is control state and is reset; RAM contents are never reset.
      tag_pipe       <= '0;
    end else begin
      ram_write <= wr_any;
      ram_read  <= rd_fire;
      if (wr_any) begin
        ram_wr_address <= wr_addr_win;
        ram_data_in    <= wr_data_win;
        wr_ptr         <= ~wr_sel;
      end
      if (rd_fire) begin
        ram_rd_address <= rd_addr_win;
        rd_ptr         <= ~rd_sel;
      end
      // One stage for the address register, RD_LAT more for the RAM itself.
      tag_pipe <= {tag_pipe[RD_LAT-1:0], bus.rd_gnt};
    end
  end

  assign bus.rd_valid = tag_pipe[RD_LAT];
  assign bus.rd_data  = ram_data_out;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT 1 and 3) driven identically, each with
// a behavioural RAM, compared every cycle against a transaction-level model.
module tb_ram_dp_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ram_dp_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  ram_dp_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  assign bus3.wr_req   = bus1.wr_req;
  assign bus3.wr_addr0 = bus1.wr_addr0;
  assign bus3.wr_addr1 = bus1.wr_addr1;
  assign bus3.wr_data0 = bus1.wr_data0;
  assign bus3.wr_data1 = bus1.wr_data1;
  assign bus3.rd_req   = bus1.rd_req;
  assign bus3.rd_addr0 = bus1.rd_addr0;
  assign bus3.rd_addr1 = bus1.rd_addr1;

  logic          r1_write, r1_read, r3_write, r3_read;
  logic [AW-1:0] r1_wa, r1_ra, r3_wa, r3_ra;
  logic [DW-1:0] r1_din, r1_dout, r3_din, r3_dout;

  ram_dp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave),
    .ram_write(r1_write), .ram_wr_address(r1_wa), .ram_data_in(r1_din),
    .ram_read(r1_read), .ram_rd_address(r1_ra), .ram_data_out(r1_dout)
  );

  ram_dp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u3 (
    .clk(clk), .resetn(resetn), .bus(bus3.slave),
    .ram_write(r3_write), .ram_wr_address(r3_wa), .ram_data_in(r3_din),
    .ram_read(r3_read), .ram_rd_address(r3_ra), .ram_data_out(r3_dout)
  );

  // Behavioural RAMs: read-before-write, output valid RD_LAT edges after sampling.
  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] mem3 [4096];
  logic [DW-1:0] q1;
  logic [DW-1:0] q3 [3];

  always @(posedge clk) begin
    if (r1_write) mem1[r1_wa] <= r1_din;
    q1 <= mem1[r1_ra];
    if (r3_write) mem3[r3_wa] <= r3_din;
    q3[0] <= mem3[r3_ra];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign r1_dout = q1;
  assign r3_dout = q3[2];

  // Reference model state
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            wptr, rptr;
  bit            known = 1'b0;
  logic [DW-1:0] mmem [4096];
  logic          e_write, e_read;
  logic [AW-1:0] e_wa, e_ra;
  logic [DW-1:0] e_wd;
  logic [1:0]    p1_tag [int];
  logic [1:0]    p3_tag [int];
  logic [DW-1:0] p1_dat [int];
  logic [DW-1:0] p3_dat [int];
  logic [1:0]    exp_wg, exp_rg, obs_wg, obs_rg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [1:0] req, input int ptr);
    if (req == 2'b11) return ptr;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic step(input logic rn, input logic [1:0] wq,
                      input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                      input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                      input logic [1:0] rq,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    int            wk, rk;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [1:0]    t1, t3;
    resetn        = rn;
    bus1.wr_req   = wq;
    bus1.wr_addr0 = wa0;
    bus1.wr_addr1 = wa1;
    bus1.wr_data0 = wd0;
    bus1.wr_data1 = wd1;
    bus1.rd_req   = rq;
    bus1.rd_addr0 = ra0;
    bus1.rd_addr1 = ra1;
    @(negedge clk);
    wk = rn ? pick(wq, wptr) : -1;
    rk = rn ? pick(rq, rptr) : -1;
    wa = (wk == 1) ? wa1 : wa0;
    wd = (wk == 1) ? wd1 : wd0;
    ra = (rk == 1) ? ra1 : ra0;
    if (wk >= 0 && rk >= 0 && wa == ra) rk = -1;
    exp_wg = (wk < 0) ? 2'b00 : 2'(2'b01 << wk);
    exp_rg = (rk < 0) ? 2'b00 : 2'(2'b01 << rk);
    obs_wg = bus1.wr_gnt;
    obs_rg = bus1.rd_gnt;
    check("wr_gnt_l1", bus1.wr_gnt, exp_wg);
    check("rd_gnt_l1", bus1.rd_gnt, exp_rg);
    check("wr_gnt_l3", bus3.wr_gnt, exp_wg);
    check("rd_gnt_l3", bus3.rd_gnt, exp_rg);
    if (known) begin
      check("ram_write_l1", r1_write, e_write);
      check("ram_wr_address_l1", r1_wa, e_wa);
      check("ram_data_in_l1", r1_din, e_wd);
      check("ram_read_l1", r1_read, e_read);
      check("ram_rd_address_l1", r1_ra, e_ra);
      check("ram_write_l3", r3_write, e_write);
      check("ram_read_l3", r3_read, e_read);
      check("ram_rd_address_l3", r3_ra, e_ra);
      t1 = p1_tag.exists(cyc) ? p1_tag[cyc] : 2'b00;
      t3 = p3_tag.exists(cyc) ? p3_tag[cyc] : 2'b00;
      check("rd_valid_l1", bus1.rd_valid, t1);
      check("rd_valid_l3", bus3.rd_valid, t3);
      if (t1 != 2'b00) check("rd_data_l1", bus1.rd_data, p1_dat[cyc]);
      if (t3 != 2'b00) check("rd_data_l3", bus3.rd_data, p3_dat[cyc]);
    end
    if (!rn) begin
      known = 1'b1;
      wptr = 0; rptr = 0;
      e_write = 1'b0; e_read = 1'b0;
      e_wa = '0; e_ra = '0; e_wd = '0;
      p1_tag.delete(); p3_tag.delete(); p1_dat.delete(); p3_dat.delete();
    end else begin
      e_write = (wk >= 0);
      e_read  = (rk >= 0);
      if (rk >= 0) begin
        e_ra = ra;
        p1_tag[cyc + 2] = exp_rg;
        p1_dat[cyc + 2] = mmem[ra];
        p3_tag[cyc + 4] = exp_rg;
        p3_dat[cyc + 4] = mmem[ra];
        rptr = 1 - rk;
      end
      if (wk >= 0) begin
        e_wa = wa;
        e_wd = wd;
        mmem[wa] = wd;
        wptr = 1 - wk;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  logic [1:0]    wq, rq;
  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] wd [2];
  int            i0, i1;

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem1[a] = '0;
      mem3[a] = '0;
      mmem[a] = '0;
    end
    resetn = 1'b0;
    bus1.wr_req = 2'b00;
    bus1.rd_req = 2'b00;
    @(posedge clk);
    #1;

    // Reset with everything requesting: no grants, outputs cleared
    for (int j = 0; j < 3; j++)
      step(1'b0, 2'b11, 12'h000, 12'hFFF, 64'h1, 64'h2, 2'b11, 12'h100, 12'h200);

    // Round-robin contention on both channels, starting at requester 0
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 2'b11, 12'h000, 12'hFFF, 64'hA0 + 64'(j), 64'hB0 + 64'(j),
           2'b11, 12'h100, 12'h200);
      check("rr_wr_seq", obs_wg, (j % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_rd_seq", obs_rg, (j % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle(5);

    // Single write then read-back by requester 0
    step(1'b1, 2'b01, 12'h123, '0, 64'hDEAD_BEEF_0000_0001, '0, 2'b00, '0, '0);
    step(1'b1, 2'b00, '0, '0, '0, '0, 2'b01, 12'h123, '0);
    idle(5);

    // Same-address hazard: read stalls one cycle, returns the new data
    step(1'b1, 2'b01, 12'h0AA, '0, 64'h5555, '0, 2'b10, '0, 12'h0AA);
    check("hazard_stall", obs_rg, 2'b00);
    step(1'b1, 2'b00, '0, '0, '0, '0, 2'b10, '0, 12'h0AA);
    check("hazard_retry", obs_rg, 2'b10);
    idle(5);

    // Preload 0x001..0x008, then alternating back-to-back reads
    for (int j = 1; j <= 8; j++)
      step(1'b1, 2'b01, AW'(j), '0, DW'(j), '0, 2'b00, '0, '0);
    i0 = 0;
    i1 = 0;
    for (int j = 0; j < 10 && (i0 < 4 || i1 < 4); j++) begin
      step(1'b1, 2'b00, '0, '0, '0, '0, {i1 < 4, i0 < 4}, AW'(1 + 2 * i0), AW'(2 + 2 * i1));
      if (exp_rg[0]) i0++;
      if (exp_rg[1]) i1++;
    end
    idle(5);

    // Reset with two reads in flight: neither returns, pointers go back to 0
    step(1'b1, 2'b00, '0, '0, '0, '0, 2'b01, 12'h005, '0);
    step(1'b1, 2'b00, '0, '0, '0, '0, 2'b10, '0, 12'h006);
    step(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
    idle(5);
    step(1'b1, 2'b11, 12'h010, 12'h011, 64'h77, 64'h88, 2'b11, 12'h020, 12'h021);
    check("post_reset_wr_ptr", obs_wg, 2'b01);
    check("post_reset_rd_ptr", obs_rg, 2'b01);
    idle(5);

    // Randomised traffic over a small address window to provoke hazards
    wq = 2'b00;
    rq = 2'b00;
    for (int k = 0; k < 2; k++) begin
      wa[k] = '0; ra[k] = '0; wd[k] = '0;
    end
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(wq[k] && !exp_wg[k])) begin
          wq[k] = 1'($urandom_range(0, 1));
          wa[k] = AW'($urandom_range(0, 15));
          wd[k] = {$urandom, $urandom};
        end
        if (!(rq[k] && !exp_rg[k])) begin
          rq[k] = 1'($urandom_range(0, 1));
          ra[k] = AW'($urandom_range(0, 15));
        end
      end
      step(($urandom_range(0, 59) != 0), wq, wa[0], wa[1], wd[0], wd[1], rq, ra[0], ra[1]);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
